// File: rtl/host_cmd_pkg.sv
// Shared constants, result/status codes and FSM state type for the host command handler.
package host_cmd_pkg;

    localparam logic [15:0] HOST_CMD_STATUS            = 16'h0000;
    localparam logic [15:0] HOST_CMD_RESET_ENTER       = 16'h0010;
    localparam logic [15:0] HOST_CMD_RESET_EXIT        = 16'h0011;
    localparam logic [15:0] HOST_CMD_DATASLOT_COMPLETE = 16'h008F;
    localparam logic [15:0] HOST_CMD_RTC               = 16'h0090;

    localparam logic [15:0] RESULT_OK      = 16'h0000;
    localparam logic [15:0] RESULT_TIMEOUT = 16'h0002;
    localparam logic [15:0] RESULT_UNKNOWN = 16'hFFFF;

    localparam logic [7:0] STATUS_BOOTING = 8'h01;
    localparam logic [7:0] STATUS_IDLE    = 8'h03;
    localparam logic [7:0] STATUS_RUNNING = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_READY,
        ST_DONE,
        ST_DRAIN
    } host_cmd_state_e;

endpackage

// File: rtl/bridge_driver_if.sv
// Command port between bridge_driver (master) and the host command handler (slave).
// Handshake: master raises valid with word/param stable; slave pulses done for one
// cycle with result/response valid; master drops valid the cycle after seeing done.
interface bridge_driver_if (
    input logic clk
);
    logic               valid;
    logic [15:0]        word;
    logic [0:3][31:0]   param;
    logic [15:0]        progress;
    logic               done;
    logic [15:0]        result;
    logic [127:0]       response;

    modport master (
        output valid, word, param,
        input  progress, done, result, response
    );

    modport slave (
        input  valid, word, param,
        output progress, done, result, response
    );
endinterface

// File: rtl/host_cmd_handler.sv
// Executes host commands from bridge_driver: status, core reset control with a
// core-ready timeout, data slot completion strobe and real-time clock update.
module host_cmd_handler
    import host_cmd_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd7_425_000
) (
    input  logic            clk,
    input  logic            reset_n,
    bridge_driver_if.slave  cmd,
    input  logic            boot_done,
    input  logic            core_ready,
    output logic            core_reset_n,
    output logic            dataslot_all_complete,
    output logic [31:0]     rtc_epoch,
    output logic [31:0]     rtc_date,
    output logic [31:0]     rtc_time,
    output logic            rtc_valid,
    output host_cmd_state_e state
);

    host_cmd_state_e state_q, state_d;
    logic [15:0]     word_q;
    logic [31:0]     param0_q, param1_q, param2_q;
    logic [31:0]     counter_q;
    logic [15:0]     result_q;
    logic [15:0]     exec_result;
    logic [7:0]      status_code;
    logic            timeout_hit;

    assign timeout_hit = (counter_q == TIMEOUT_CYCLES - 32'd1);
    assign state       = state_q;

    always_comb begin
        status_code = STATUS_RUNNING;
        if (!boot_done)
            status_code = STATUS_BOOTING;
        else if (!core_reset_n)
            status_code = STATUS_IDLE;
        case (word_q)
            HOST_CMD_STATUS:            exec_result = {8'h00, status_code};
            HOST_CMD_RESET_ENTER,
            HOST_CMD_RESET_EXIT,
            HOST_CMD_DATASLOT_COMPLETE,
            HOST_CMD_RTC:               exec_result = RESULT_OK;
            default:                    exec_result = RESULT_UNKNOWN;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (cmd.valid) state_d = ST_EXEC;
            ST_EXEC:       state_d = (word_q == HOST_CMD_RESET_EXIT) ? ST_WAIT_READY : ST_DONE;
            ST_WAIT_READY: if (core_ready || timeout_hit) state_d = ST_DONE;
            ST_DONE:       state_d = ST_DRAIN;
            // Hold here until bridge_driver drops valid so one request runs only once.
            ST_DRAIN:      if (!cmd.valid) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            param0_q     <= '0;
            param1_q     <= '0;
            param2_q     <= '0;
            counter_q    <= '0;
            result_q     <= '0;
            core_reset_n <= 1'b0;
            rtc_epoch    <= '0;
            rtc_date     <= '0;
            rtc_time     <= '0;
            rtc_valid    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rtc_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd.valid) begin
                        word_q   <= cmd.word;
                        param0_q <= cmd.param[0];
                        param1_q <= cmd.param[1];
                        param2_q <= cmd.param[2];
                    end
                end
                ST_EXEC: begin
                    if (word_q == HOST_CMD_RESET_EXIT) begin
                        core_reset_n <= 1'b1;
                        counter_q    <= '0;
                    end else begin
                        result_q <= exec_result;
                    end
                    if (word_q == HOST_CMD_RESET_ENTER)
                        core_reset_n <= 1'b0;
                    if (word_q == HOST_CMD_RTC) begin
                        rtc_epoch <= param0_q;
                        rtc_date  <= param1_q;
                        rtc_time  <= param2_q;
                        rtc_valid <= 1'b1;
                    end
                end
                ST_WAIT_READY: begin
                    // core_ready takes priority over a coincident timeout.
                    if (core_ready)
                        result_q <= RESULT_OK;
                    else if (timeout_hit)
                        result_q <= RESULT_TIMEOUT;
                    else
                        counter_q <= counter_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign cmd.done              = (state_q == ST_DONE);
    assign cmd.result            = result_q;
    assign cmd.response          = '0;
    assign cmd.progress          = (state_q == ST_WAIT_READY) ? counter_q[31:16] : 16'h0000;
    assign dataslot_all_complete = (state_q == ST_EXEC) && (word_q == HOST_CMD_DATASLOT_COMPLETE);

endmodule

// File: tb/tb_host_cmd_handler.sv
// Directed bench for host_cmd_handler: every scenario task checks against hand-computed values.
module tb_host_cmd_handler;
    import host_cmd_pkg::*;

    logic            clk;
    logic            reset_n;
    logic            boot_done;
    logic            core_ready;
    logic            core_reset_n;
    logic            dataslot_all_complete;
    logic [31:0]     rtc_epoch, rtc_date, rtc_time;
    logic            rtc_valid;
    host_cmd_state_e state;

    int checks = 0;
    int errors = 0;

    int              lat;
    logic            seen;
    int              done_pulses, rtc_pulses, ds_pulses;
    host_cmd_state_e probe_state;
    logic [15:0]     probe_progress;
    logic [15:0]     probe_result;

    bridge_driver_if cmd (.clk(clk));

    host_cmd_handler #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .cmd                   (cmd),
        .boot_done             (boot_done),
        .core_ready            (core_ready),
        .core_reset_n          (core_reset_n),
        .dataslot_all_complete (dataslot_all_complete),
        .rtc_epoch             (rtc_epoch),
        .rtc_date              (rtc_date),
        .rtc_time              (rtc_time),
        .rtc_valid             (rtc_valid),
        .state                 (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples and drives happen on the negedge; lat counts negedges since valid rose.
    task automatic sample_cycle(input int ready_at, input int probe_at);
        if (cmd.done) done_pulses++;
        if (rtc_valid) rtc_pulses++;
        if (dataslot_all_complete) ds_pulses++;
        if (lat == probe_at) begin
            probe_state    = state;
            probe_progress = cmd.progress;
            probe_result   = cmd.result;
        end
        if (lat == ready_at) core_ready = 1'b1;
    endtask

    task automatic run_cmd(input logic [15:0] w, input logic [127:0] p, input int hold,
                           input int ready_at, input int probe_at, input int max_cycles);
        done_pulses = 0; rtc_pulses = 0; ds_pulses = 0; seen = 1'b0; lat = 0;
        @(negedge clk);
        cmd.word  = w;
        cmd.param = p;
        cmd.valid = 1'b1;
        while (!seen && lat < max_cycles) begin
            @(negedge clk);
            lat++;
            if (cmd.done) seen = 1'b1;
            sample_cycle(ready_at, probe_at);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout word=%h: no done within %0d cycles", w, max_cycles);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            sample_cycle(-1, -1);
        end
        cmd.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample_cycle(-1, -1);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; boot_done = 1'b0; core_ready = 1'b0;
        cmd.valid = 1'b0; cmd.word = '0; cmd.param = '0;
        repeat (3) @(negedge clk);
        checks++; if (cmd.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", cmd.done); end
        checks++; if (cmd.result !== 16'h0000) begin errors++; $display("FAIL rst_result: got %h want 0000", cmd.result); end
        checks++; if (cmd.response !== 128'h0) begin errors++; $display("FAIL rst_response: got %h want 0", cmd.response); end
        checks++; if (cmd.progress !== 16'h0000) begin errors++; $display("FAIL rst_progress: got %h want 0000", cmd.progress); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL rst_core_reset_n: got %b want 0", core_reset_n); end
        checks++; if ({rtc_valid, dataslot_all_complete} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {rtc_valid, dataslot_all_complete}); end
        checks++; if ({rtc_epoch, rtc_date, rtc_time} !== 96'h0) begin errors++; $display("FAIL rst_rtc: got %h want 0", {rtc_epoch, rtc_date, rtc_time}); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", state, ST_IDLE); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_status;
        boot_done = 1'b0;
        run_cmd(HOST_CMD_STATUS, 128'h0, 1, -1, -1, 20);
        checks++; if (lat !== 2) begin errors++; $display("FAIL status_latency: got %0d want 2", lat); end
        checks++; if (cmd.result !== 16'h0001) begin errors++; $display("FAIL status_booting: got %h want 0001", cmd.result); end
        boot_done = 1'b1;
        run_cmd(HOST_CMD_STATUS, 128'h0, 1, -1, -1, 20);
        checks++; if (cmd.result !== 16'h0003) begin errors++; $display("FAIL status_idle: got %h want 0003", cmd.result); end
    endtask

    task automatic test_reset_exit_ready;
        core_ready = 1'b0;
        // ready rises at cycle 10, WAIT_READY sees it on the next edge -> done at 11
        run_cmd(HOST_CMD_RESET_EXIT, 128'h0, 1, 10, -1, 200);
        checks++; if (lat !== 11) begin errors++; $display("FAIL exit_latency: got %0d want 11", lat); end
        checks++; if (cmd.result !== RESULT_OK) begin errors++; $display("FAIL exit_result: got %h want 0000", cmd.result); end
        checks++; if (core_reset_n !== 1'b1) begin errors++; $display("FAIL exit_core_reset_n: got %b want 1", core_reset_n); end
        run_cmd(HOST_CMD_STATUS, 128'h0, 1, -1, -1, 20);
        checks++; if (cmd.result !== 16'h0004) begin errors++; $display("FAIL status_running: got %h want 0004", cmd.result); end
    endtask

    task automatic test_reset_exit_timeout;
        core_ready = 1'b0;
        run_cmd(HOST_CMD_RESET_EXIT, 128'h0, 1, -1, 50, 300);
        checks++; if (lat !== 102) begin errors++; $display("FAIL timeout_latency: got %0d want 102", lat); end
        checks++; if (cmd.result !== RESULT_TIMEOUT) begin errors++; $display("FAIL timeout_result: got %h want 0002", cmd.result); end
        checks++; if (core_reset_n !== 1'b1) begin errors++; $display("FAIL timeout_core_reset_n: got %b want 1", core_reset_n); end
        checks++; if (probe_state !== ST_WAIT_READY) begin errors++; $display("FAIL wait_state: got %0d want %0d", probe_state, ST_WAIT_READY); end
        checks++; if (probe_progress !== 16'h0000) begin errors++; $display("FAIL wait_progress: got %h want 0000", probe_progress); end
        checks++; if (probe_result !== 16'h0004) begin errors++; $display("FAIL wait_result_hold: got %h want 0004", probe_result); end
    endtask

    task automatic test_reset_enter;
        for (int i = 0; i < 2; i++) begin
            run_cmd(HOST_CMD_RESET_ENTER, 128'h0, 1, -1, -1, 20);
            checks++; if (cmd.result !== RESULT_OK) begin errors++; $display("FAIL enter_result[%0d]: got %h want 0000", i, cmd.result); end
            checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL enter_core_reset_n[%0d]: got %b want 0", i, core_reset_n); end
        end
        run_cmd(HOST_CMD_STATUS, 128'h0, 1, -1, -1, 20);
        checks++; if (cmd.result !== 16'h0003) begin errors++; $display("FAIL enter_status: got %h want 0003", cmd.result); end
    endtask

    task automatic test_ready_already;
        core_ready = 1'b1;
        run_cmd(HOST_CMD_RESET_EXIT, 128'h0, 1, -1, -1, 50);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ready_already_latency: got %0d want 3", lat); end
        checks++; if (cmd.result !== RESULT_OK) begin errors++; $display("FAIL ready_already_result: got %h want 0000", cmd.result); end
        checks++; if (core_reset_n !== 1'b1) begin errors++; $display("FAIL ready_already_core_reset_n: got %b want 1", core_reset_n); end
    endtask

    task automatic test_rtc;
        run_cmd(HOST_CMD_RTC, {32'h6543_2100, 32'h2024_0131, 32'h0012_3456, 32'h0}, 1, -1, -1, 20);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rtc_latency: got %0d want 2", lat); end
        checks++; if (rtc_epoch !== 32'h6543_2100) begin errors++; $display("FAIL rtc_epoch: got %h want 65432100", rtc_epoch); end
        checks++; if (rtc_date !== 32'h2024_0131) begin errors++; $display("FAIL rtc_date: got %h want 20240131", rtc_date); end
        checks++; if (rtc_time !== 32'h0012_3456) begin errors++; $display("FAIL rtc_time: got %h want 00123456", rtc_time); end
        checks++; if (rtc_pulses !== 1) begin errors++; $display("FAIL rtc_valid_pulses: got %0d want 1", rtc_pulses); end
        checks++; if (cmd.result !== RESULT_OK) begin errors++; $display("FAIL rtc_result: got %h want 0000", cmd.result); end
    endtask

    task automatic test_dataslot;
        run_cmd(HOST_CMD_DATASLOT_COMPLETE, 128'h0, 1, -1, -1, 20);
        checks++; if (ds_pulses !== 1) begin errors++; $display("FAIL dataslot_pulses: got %0d want 1", ds_pulses); end
        checks++; if (rtc_pulses !== 0) begin errors++; $display("FAIL dataslot_rtc_pulses: got %0d want 0", rtc_pulses); end
        checks++; if (cmd.result !== RESULT_OK) begin errors++; $display("FAIL dataslot_result: got %h want 0000", cmd.result); end
    endtask

    task automatic test_unknown_hold;
        run_cmd(16'h1234, {32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333}, 3, -1, -1, 20);
        checks++; if (done_pulses !== 1) begin errors++; $display("FAIL unknown_done_pulses: got %0d want 1", done_pulses); end
        checks++; if (cmd.result !== RESULT_UNKNOWN) begin errors++; $display("FAIL unknown_result: got %h want ffff", cmd.result); end
        checks++; if (rtc_epoch !== 32'h6543_2100) begin errors++; $display("FAIL unknown_rtc_epoch: got %h want 65432100", rtc_epoch); end
        checks++; if (core_reset_n !== 1'b1) begin errors++; $display("FAIL unknown_core_reset_n: got %b want 1", core_reset_n); end
        checks++; if ((rtc_pulses + ds_pulses) !== 0) begin errors++; $display("FAIL unknown_strobes: got %0d want 0", rtc_pulses + ds_pulses); end
    endtask

    task automatic test_reset_mid;
        core_ready = 1'b0;
        @(negedge clk);
        cmd.word  = HOST_CMD_RESET_EXIT;
        cmd.param = '0;
        cmd.valid = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (state !== ST_WAIT_READY) begin errors++; $display("FAIL mid_pre_state: got %0d want %0d", state, ST_WAIT_READY); end
        reset_n = 1'b0;
        #1;
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL mid_core_reset_n: got %b want 0", core_reset_n); end
        checks++; if (cmd.done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", cmd.done); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL mid_state: got %0d want %0d", state, ST_IDLE); end
        checks++; if (cmd.result !== 16'h0000) begin errors++; $display("FAIL mid_result: got %h want 0000", cmd.result); end
        @(negedge clk);
        cmd.valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_cmd(HOST_CMD_STATUS, 128'h0, 1, -1, -1, 20);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_next_latency: got %0d want 2", lat); end
        checks++; if (cmd.result !== 16'h0003) begin errors++; $display("FAIL mid_next_result: got %h want 0003", cmd.result); end
    endtask

    initial begin
        test_reset;
        test_status;
        test_reset_exit_ready;
        test_reset_exit_timeout;
        test_reset_enter;
        test_ready_already;
        test_rtc;
        test_dataslot;
        test_unknown_hold;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
